// File: rtl/io_port_pkg.sv
// io_port_pkg: shared constants for the IO-bus to UART bridge.
//   Port IDs, read-back encodings for status ports and bit positions
//   within the error-flag register.
package io_port_pkg;

  localparam logic [7:0] PORT_DATA   = 8'h01;
  localparam logic [7:0] PORT_RXSTAT = 8'h02;
  localparam logic [7:0] PORT_TXSTAT = 8'h03;
  localparam logic [7:0] PORT_ERR    = 8'h04;
  localparam logic [7:0] PORT_CTRL   = 8'h05;

  localparam logic [7:0] STAT_TRUE  = 8'hFF;
  localparam logic [7:0] STAT_FALSE = 8'h00;
  localparam logic [7:0] UNMAPPED   = 8'hFF;

  localparam int unsigned ERR_RXOVR  = 0;
  localparam int unsigned ERR_TXDROP = 1;

  // Status ports report a condition as all-ones / all-zeros.
  function automatic logic [7:0] stat_byte(input logic cond);
    return cond ? STAT_TRUE : STAT_FALSE;
  endfunction

endpackage

// File: rtl/io_tx_fifo.sv
// io_tx_fifo: synchronous byte FIFO feeding the UART transmitter.
//   clk_i    clock
//   rst_i    synchronous active-high reset (pointers/count cleared)
//   push_i   write data_i this cycle (accepted if not full or popping)
//   data_i   byte to push
//   pop_i    request removal of head (ignored while empty)
//   data_o   head entry, 0x00 while empty
//   empty_o  FIFO holds no bytes
//   drop_o   push requested but rejected this cycle
//   count_o  occupancy, 0..Depth
module io_tx_fifo #(
  parameter int unsigned Depth = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic [7:0]             data_i,
  input  logic                   pop_i,
  output logic [7:0]             data_o,
  output logic                   empty_o,
  output logic                   drop_o,
  output logic [$clog2(Depth):0] count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [7:0]      mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            full, pop_en, push_en;

  assign full    = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign pop_en  = pop_i && !empty_o;
  // A pop in the same cycle frees the slot a full FIFO needs.
  assign push_en = push_i && (!full || pop_en);
  assign drop_o  = push_i && !push_en;
  assign count_o = count_q;
  assign data_o  = empty_o ? 8'h00 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Depth is a power of two, so pointer overflow is the modulo wrap.
    if (push_en) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop_en)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    unique case ({push_en, pop_en})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: data_o is masked while empty.
  always_ff @(posedge clk_i) begin
    if (push_en) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/io_port_ctrl.sv
// io_port_ctrl: bridges the processor IO bus to a UART byte interface.
//   clk100/reset      clock, synchronous active-high reset
//   IO_port_ID        port address (0x01 data, 0x02 RX status,
//                     0x03 TX status, 0x04 error flags)
//   IO_write_data/IO_write_strobe, IO_read_strobe: processor access
//   IO_read_data      registered read data, held until next read
//   tx_data/tx_valid/tx_ready   TX FIFO head towards the UART
//   rx_data/rx_valid            received byte pulse from the UART
// Build option IO_LOOPBACK_EN adds control port 0x05 (bit0 = loopback),
// which routes the TX FIFO internally into the RX holding register.
module io_port_ctrl
  import io_port_pkg::*;
#(
  parameter int unsigned TX_DEPTH = 8
) (
  input  logic       clk100,
  input  logic       reset,
  input  logic [7:0] IO_port_ID,
  input  logic [7:0] IO_write_data,
  input  logic       IO_write_strobe,
  input  logic       IO_read_strobe,
  output logic [7:0] IO_read_data,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  input  logic [7:0] rx_data,
  input  logic       rx_valid
);

  localparam int unsigned CNT_W = $clog2(TX_DEPTH) + 1;

  logic             wr_q, rd_q, wr_evt, rd_evt;
  logic [7:0]       rd_data_q, rd_data_d;
  logic             rx_present_q, rx_present_d;
  logic [7:0]       rx_hold_q, rx_hold_d;
  logic             tx_drop_q, tx_drop_d;
  logic             rx_overrun_q, rx_overrun_d;
  logic [7:0]       err_flags;
  logic             rx_in_valid;
  logic [7:0]       rx_in_data;
  logic             data_rd, err_clr;
  logic             fifo_push, fifo_pop, fifo_empty, fifo_drop, tx_full;
  logic [7:0]       fifo_head;
  logic [CNT_W-1:0] fifo_count;

  // Rising-edge qualification: a held strobe acts once.
  assign wr_evt = IO_write_strobe && !wr_q;
  assign rd_evt = IO_read_strobe && !rd_q;

  assign data_rd   = rd_evt && (IO_port_ID == PORT_DATA);
  assign err_clr   = (rd_evt || wr_evt) && (IO_port_ID == PORT_ERR);
  assign fifo_push = wr_evt && (IO_port_ID == PORT_DATA);
  assign tx_full   = (fifo_count == CNT_W'(TX_DEPTH));
  assign tx_data   = fifo_head;

  io_tx_fifo #(
    .Depth (TX_DEPTH)
  ) u_tx_fifo (
    .clk_i   (clk100),
    .rst_i   (reset),
    .push_i  (fifo_push),
    .data_i  (IO_write_data),
    .pop_i   (fifo_pop),
    .data_o  (fifo_head),
    .empty_o (fifo_empty),
    .drop_o  (fifo_drop),
    .count_o (fifo_count)
  );

`ifdef IO_LOOPBACK_EN
  logic loopback_q, loopback_d;

  always_comb begin
    loopback_d = loopback_q;
    if (wr_evt && (IO_port_ID == PORT_CTRL)) loopback_d = IO_write_data[0];
  end

  always_ff @(posedge clk100) begin
    if (reset) loopback_q <= 1'b0;
    else       loopback_q <= loopback_d;
  end

  // In loopback the UART is cut off and the FIFO drains into RX each cycle.
  assign tx_valid    = !fifo_empty && !loopback_q;
  assign fifo_pop    = loopback_q ? !fifo_empty : (tx_valid && tx_ready);
  assign rx_in_valid = loopback_q ? !fifo_empty : rx_valid;
  assign rx_in_data  = loopback_q ? fifo_head : rx_data;
`else
  assign tx_valid    = !fifo_empty;
  assign fifo_pop    = tx_valid && tx_ready;
  assign rx_in_valid = rx_valid;
  assign rx_in_data  = rx_data;
`endif

  always_comb begin
    err_flags             = 8'h00;
    err_flags[ERR_RXOVR]  = rx_overrun_q;
    err_flags[ERR_TXDROP] = tx_drop_q;
  end

  // Read mux, sampled into rd_data_q on the qualified read edge.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_evt) begin
      case (IO_port_ID)
        PORT_DATA:   rd_data_d = rx_hold_q;
        PORT_RXSTAT: rd_data_d = stat_byte(rx_present_q);
        PORT_TXSTAT: rd_data_d = stat_byte(tx_full);
        PORT_ERR:    rd_data_d = err_flags;
`ifdef IO_LOOPBACK_EN
        PORT_CTRL:   rd_data_d = {7'b0, loopback_q};
`endif
        default:     rd_data_d = UNMAPPED;
      endcase
    end
  end

  // RX holding register and sticky flags; a set event beats a clear.
  always_comb begin
    rx_hold_d    = rx_hold_q;
    rx_present_d = rx_present_q;
    if (rx_in_valid) begin
      rx_hold_d    = rx_in_data;
      rx_present_d = 1'b1;
    end else if (data_rd) begin
      rx_present_d = 1'b0;
    end
    rx_overrun_d = (rx_overrun_q && !err_clr) || (rx_in_valid && rx_present_q && !data_rd);
    tx_drop_d    = (tx_drop_q && !err_clr) || fifo_drop;
  end

  always_ff @(posedge clk100) begin
    if (reset) begin
      wr_q         <= 1'b0;
      rd_q         <= 1'b0;
      rd_data_q    <= 8'h00;
      rx_present_q <= 1'b0;
      rx_hold_q    <= 8'h00;
      tx_drop_q    <= 1'b0;
      rx_overrun_q <= 1'b0;
    end else begin
      wr_q         <= IO_write_strobe;
      rd_q         <= IO_read_strobe;
      rd_data_q    <= rd_data_d;
      rx_present_q <= rx_present_d;
      rx_hold_q    <= rx_hold_d;
      tx_drop_q    <= tx_drop_d;
      rx_overrun_q <= rx_overrun_d;
    end
  end

  assign IO_read_data = rd_data_q;

endmodule
